mul_div_unit: RTL
=================

# mul_div_unit

Iterative RV64M multiply/divide execute unit sitting between the 32×64-bit register file and its write port. It takes rs1/rs2 read data, computes one of the eight M-extension results over a fixed number of cycles, and drives `write_reg`, `write_data` and `reg_write` back into the register file. It is a multi-cycle functional unit with a start/busy handshake.

## Interface
- `XLEN`, 64: operand and result width; also the iteration count.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low; sampled on the rising edge of `clock`.
- `start`  in  1: request; sampled only in IDLE.
- `funct3`  in  3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rd`  in  5: destination register index.
- `rs1_data`  in  XLEN: operand A (multiplicand/dividend).
- `rs2_data`  in  XLEN: operand B (multiplier/divisor).
- `busy`  out  1: high whenever the unit is not IDLE.
- `reg_write`  out  1: one-cycle write-enable pulse to the register file.
- `write_reg`  out  5: destination index for the write.
- `write_data`  out  XLEN: result.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: on an edge with `reset`=1 and `start`=1, latch `funct3`, `rd`, operand magnitudes and result-sign flags; clear the iteration counter; go to RUN.
- Signedness:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats A as signed, B as unsigned.
  - MUL, MULHU, DIVU and REMU treat both operands as unsigned.
  - MUL's low half is sign-agnostic.
- RUN: one iteration per cycle for exactly XLEN cycles.
  - Multiply: shift-add into a 2·XLEN product.
  - Divide: restoring shift-subtract giving an XLEN quotient and remainder.
  - When the counter reaches XLEN−1, go to DONE.
- DONE: apply the sign fix and result select.
  - MUL returns product[63:0]; MULH/MULHSU/MULHU return product[127:64].
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Signed quotient is negated when the operand signs differ; signed remainder takes the dividend's sign.
  - Drive `write_data` and `write_reg`=latched `rd`; `reg_write`=1 unless `rd`=0. Next edge returns to IDLE.
- Special cases, with the same latency as normal ops:
  - Divide by zero: quotient = all ones (both DIV and DIVU); remainder = dividend.
  - Signed overflow (−2^63 / −1): quotient = −2^63, remainder = 0.
- `start` outside IDLE is ignored; the request is dropped, not queued.
- `write_reg` and `write_data` hold their last values after DONE until the next DONE.

## Timing
- Reset: edge with `reset`=0 forces IDLE. Outputs `busy`=0, `reg_write`=0, `write_reg`=0, `write_data`=0. Takes effect at that edge regardless of state.
- Accept at edge E0:
  - `busy`=1 from E0.
  - RUN occupies E0..E0+64.
  - DONE cycle is E0+64..E0+65, with `reg_write` high for exactly that one cycle.
  - `busy`=0 after E0+65.
- Earliest next accept is edge E0+66. Throughput is one op per 66 cycles.
- Operands and `rd` are captured at E0 only; input changes during RUN have no effect.
- Reset mid-RUN or in DONE: no `reg_write` pulse, partial result discarded.
- The register file captures `write_data` on the edge ending the DONE cycle.

## Test plan
- MUL, A=7, B=−3, `rd`=5:
  - `write_data`=0xFFFF_FFFF_FFFF_FFEB, `write_reg`=5.
  - `reg_write` high only during E0+64..E0+65; `busy` falls after E0+65.
- High-half multiplies:
  - MULHU, A=0xFFFF_FFFF_FFFF_FFFF, B=2 → 0x1.
  - MULH, A=−1, B=−1 → 0x0.
  - MULHSU, A=−1, B=2 → 0xFFFF_FFFF_FFFF_FFFF.
- Signed division:
  - DIV, A=−7, B=2 → 0xFFFF_FFFF_FFFF_FFFD.
  - REM, A=−7, B=2 → 0xFFFF_FFFF_FFFF_FFFF.
  - DIVU, A=100, B=7 → 14; REMU, same operands → 2.
- Edge cases, each at full 66-cycle latency:
  - DIVU, B=0 → all ones.
  - REM, A=5, B=0 → 5.
  - DIV, A=0x8000_0000_0000_0000, B=−1 → 0x8000_0000_0000_0000.
  - REM, same operands → 0.
- Control:
  - `start` pulsed with new operands at E0+10 → ignored; the first result is unchanged and there is no second pulse.
  - `reset`=0 at E0+30 → `busy`=0 after that edge, and no `reg_write` for the next 70 cycles.
  - `rd`=0 → `reg_write` stays 0, `busy` timing unchanged.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV64M multiply/divide execute unit.
//
// Ports:
//   clock, reset       - rising-edge clock, synchronous active-low reset
//   start              - request, honoured only while idle
//   funct3, rd         - M-extension operation and destination register
//   rs1_data, rs2_data - operand A (multiplicand/dividend), B (multiplier/divisor)
//   busy               - high whenever the unit is not idle
//   reg_write          - one-cycle register file write enable (never for x0)
//   write_reg          - destination index of the write
//   write_data         - result, held until the next completion
//
// Multiply and divide share one accumulator pair: acc_hi is the running
// product high half / partial remainder, acc_lo is the multiplier being
// consumed / dividend being shifted out and quotient being shifted in.
// Both run on operand magnitudes; signs are applied once at the end.

module mul_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [4:0]      rd,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            reg_write,
    output logic [4:0]      write_reg,
    output logic [XLEN-1:0] write_data
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [2:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] opnd;
    logic            neg_res;
    logic            neg_rem;
    logic            div_zero;

    // Operand decode for the request presented this cycle.
    logic            signed_a;
    logic            signed_b;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;

    always_comb begin
        signed_a = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
                   (funct3 == OP_DIV)  || (funct3 == OP_REM);
        signed_b = (funct3 == OP_MULH) || (funct3 == OP_DIV) ||
                   (funct3 == OP_REM);
        a_neg    = signed_a && rs1_data[XLEN-1];
        b_neg    = signed_b && rs2_data[XLEN-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
    end

    // One iteration of each algorithm.
    logic [XLEN:0]   mul_sum;
    logic [XLEN-1:0] mul_hi_n;
    logic [XLEN-1:0] mul_lo_n;
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic            div_fit;
    logic [XLEN-1:0] div_hi_n;
    logic [XLEN-1:0] div_lo_n;
    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] lo_n;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} +
                   (acc_lo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
        mul_hi_n = mul_sum[XLEN:1];
        mul_lo_n = {mul_sum[0], acc_lo[XLEN-1:1]};

        // Restoring step: keep the difference only when it does not borrow.
        div_shift = {acc_hi, acc_lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd};
        div_fit   = !div_diff[XLEN];
        div_hi_n  = div_fit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_lo_n  = {acc_lo[XLEN-2:0], div_fit};

        hi_n = op_q[2] ? div_hi_n : mul_hi_n;
        lo_n = op_q[2] ? div_lo_n : mul_lo_n;
    end

    // Sign fix and result select, taken from the final iteration so the
    // result is registered on the same edge that enters DONE.
    logic [2*XLEN-1:0] prod_u;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;
    logic [XLEN-1:0]   result;

    always_comb begin
        prod_u = {hi_n, lo_n};
        prod_s = neg_res ? -prod_u : prod_u;
        // Division by zero yields all ones regardless of signedness; the
        // remainder path already equals the dividend in that case.
        quo_s  = div_zero ? {XLEN{1'b1}} : (neg_res ? -lo_n : lo_n);
        rem_s  = neg_rem ? -hi_n : hi_n;
        result = '0;
        unique case (1'b1)
            (op_q == OP_MUL):
                result = prod_s[XLEN-1:0];
            (!op_q[2] && op_q != OP_MUL):
                result = prod_s[2*XLEN-1:XLEN];
            (op_q[2:1] == 2'b10):
                result = quo_s;
            (op_q[2:1] == 2'b11):
                result = rem_s;
            default:
                result = '0;
        endcase
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            opnd       <= '0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            div_zero   <= 1'b0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        count    <= '0;
                        op_q     <= funct3;
                        rd_q     <= rd;
                        acc_hi   <= '0;
                        acc_lo   <= funct3[2] ? a_mag : b_mag;
                        opnd     <= funct3[2] ? b_mag : a_mag;
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= funct3[2] && (rs2_data == '0);
                    end
                end
                ST_RUN: begin
                    acc_hi <= hi_n;
                    acc_lo <= lo_n;
                    count  <= count + 1'b1;
                    if (count == CW'(XLEN-1)) begin
                        state      <= ST_DONE;
                        write_data <= result;
                        write_reg  <= rd_q;
                        reg_write  <= (rd_q != 5'd0);
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    reg_write <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    reg_write <= 1'b0;
                end
            endcase
        end
    end

endmodule
